// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the RV32M/RV64M multiply/divide unit.
//   funct3_e : M-extension funct3 encodings (MUL..REMU)
//   state_e  : control FSM states of muldiv_unit
//   helpers  : funct3 classification used by the top level
package muldiv_unit_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDiv,
    StDone
  } state_e;

  // funct3[2] clear selects the multiply group.
  function automatic logic is_mul_op(logic [2:0] f);
    return !f[2];
  endfunction

  function automatic logic is_signed_div(logic [2:0] f);
    return (f == OpDiv) || (f == OpRem);
  endfunction

  // Within the divide group funct3[1] selects the remainder.
  function automatic logic is_rem_op(logic [2:0] f);
    return f[1];
  endfunction

endpackage

// File: rtl/muldiv_unit_div_core.sv
// Unsigned iterative restoring divider, one quotient bit per cycle.
//   clk_i, rst_i            : clock, asynchronous active-high reset
//   start_i                 : load operands and begin (ignored while abort_i)
//   abort_i                 : drop any divide in progress
//   dividend_i, divisor_i   : unsigned operands, sampled on start_i
//   busy_o                  : iteration in progress
//   done_o                  : one-cycle pulse, XLEN cycles after the start edge
//   quotient_o, remainder_o : results, valid while done_o is high
module div_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic            abort_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int unsigned CntW = $clog2(XLEN + 1);

  logic [XLEN-1:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d, done_q, done_d;

  // Partial remainder shifted left by one with the next dividend bit brought in.
  logic [XLEN:0]   rem_shift;
  logic [XLEN:0]   rem_diff;
  logic            fits;

  assign rem_shift = {rem_q, quo_q[XLEN-1]};
  assign fits      = rem_shift >= {1'b0, dvs_q};
  assign rem_diff  = rem_shift - {1'b0, dvs_q};

  always_comb begin
    quo_d  = quo_q;
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = 1'b0;
    if (abort_i) begin
      busy_d = 1'b0;
    end else if (start_i) begin
      quo_d  = dividend_i;
      rem_d  = '0;
      dvs_d  = divisor_i;
      cnt_d  = CntW'(XLEN);
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Both branches leave a value below the divisor, so XLEN bits suffice.
      rem_d = fits ? XLEN'(rem_diff) : XLEN'(rem_shift);
      quo_d = {quo_q[XLEN-2:0], fits};
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      quo_q  <= '0;
      rem_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RISC-V M-extension multiply/divide unit, one operation in flight.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : request handshake (ready only when idle)
//   funct3, in1, in2     : operation and operands, registered on accept
//   flush                : abandon any in-flight op, back to idle next cycle
//   out_valid / out_ready: result handshake, out held stable until taken
//   out                  : result
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned MUL_STAGES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out
);

  localparam int unsigned PipeDepth = MUL_STAGES - 1;

  state_e          state_q, state_d;
  funct3_e         op_q, op_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
  logic [1:0]      mcnt_q, mcnt_d;
  logic            special_q, special_d, q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  // Request-side decode, evaluated on the raw inputs at accept time.
  logic            accept, in_signed, in1_neg, in2_neg, in_special;
  logic [XLEN-1:0] mag1, mag2;

  assign accept     = in_valid && in_ready && !flush;
  assign in_signed  = is_signed_div(funct3);
  assign in1_neg    = in_signed && in1[XLEN-1];
  assign in2_neg    = in_signed && in2[XLEN-1];
  assign mag1       = in1_neg ? -in1 : in1;
  assign mag2       = in2_neg ? -in2 : in2;
  // Divide by zero and signed overflow bypass the iterative core.
  assign in_special = (in2 == '0) ||
                      (in_signed && (in1 == {1'b1, {(XLEN-1){1'b0}}}) && (in2 == '1));

  // Multiplier: one (XLEN+1)x(XLEN+1) signed product; the extra bit carries signedness.
  logic                   a_sx, b_sx;
  logic [XLEN:0]          a_ext, b_ext;
  logic signed [2*XLEN+1:0] a_wide, b_wide, prod;
  logic [XLEN-1:0]        mul_sel, mul_res;
  logic                   unused_prod;

  assign a_sx    = (op_q != OpMulhu) && a_q[XLEN-1];
  assign b_sx    = ((op_q == OpMul) || (op_q == OpMulh)) && b_q[XLEN-1];
  assign a_ext   = {a_sx, a_q};
  assign b_ext   = {b_sx, b_q};
  assign a_wide  = signed'({{(XLEN+1){a_ext[XLEN]}}, a_ext});
  assign b_wide  = signed'({{(XLEN+1){b_ext[XLEN]}}, b_ext});
  assign prod    = a_wide * b_wide;
  assign mul_sel = (op_q == OpMul) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
  assign unused_prod = ^prod[2*XLEN+1:2*XLEN];

  if (PipeDepth > 0) begin : g_mul_pipe
    logic [XLEN-1:0] pipe_q [PipeDepth];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < int'(PipeDepth); i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= mul_sel;
        for (int i = 1; i < int'(PipeDepth); i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign mul_res = pipe_q[PipeDepth-1];
  end else begin : g_mul_comb
    assign mul_res = mul_sel;
  end

  // Divider on operand magnitudes; sign fix-up and corner cases handled here.
  logic            div_start, div_done, unused_div_busy;
  logic [XLEN-1:0] div_quo, div_rem, q_fix, r_fix, div_res, special_res;

  assign div_start = accept && !is_mul_op(funct3) && !in_special;

  div_core #(
    .XLEN(XLEN)
  ) u_div_core (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (div_start),
    .abort_i    (flush),
    .dividend_i (mag1),
    .divisor_i  (mag2),
    .busy_o     (unused_div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );

  assign q_fix   = q_neg_q ? -div_quo : div_quo;
  assign r_fix   = r_neg_q ? -div_rem : div_rem;
  assign div_res = is_rem_op(op_q) ? r_fix : q_fix;
  // b_q == 0 distinguishes divide-by-zero from signed overflow.
  assign special_res = (b_q == '0) ? (is_rem_op(op_q) ? a_q : '1)
                                   : (is_rem_op(op_q) ? '0  : a_q);

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    out_d     = out_q;
    mcnt_d    = mcnt_q;
    special_d = special_q;
    q_neg_d   = q_neg_q;
    r_neg_d   = r_neg_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d      = funct3_e'(funct3);
          a_d       = in1;
          b_d       = in2;
          mcnt_d    = '0;
          special_d = in_special;
          q_neg_d   = in1_neg ^ in2_neg;
          r_neg_d   = in1_neg;
          state_d   = is_mul_op(funct3) ? StMul : StDiv;
        end
      end
      StMul: begin
        if (mcnt_q == 2'(PipeDepth)) begin
          out_d   = mul_res;
          state_d = StDone;
        end else begin
          mcnt_d = mcnt_q + 2'd1;
        end
      end
      StDiv: begin
        if (special_q) begin
          out_d   = special_res;
          state_d = StDone;
        end else if (div_done) begin
          out_d   = div_res;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= OpMul;
      a_q       <= '0;
      b_q       <= '0;
      out_q     <= '0;
      mcnt_q    <= '0;
      special_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      out_q     <= out_d;
      mcnt_q    <= mcnt_d;
      special_q <= special_d;
      q_neg_q   <= q_neg_d;
      r_neg_q   <= r_neg_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out       = out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: a 32-bit instance with a
// two-stage multiplier and a 64-bit instance with the default single stage.
module tb_muldiv_unit;

  localparam int MS32 = 2;
  localparam int MS64 = 1;
  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
  localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        v32 = 0, fl32 = 0, ord32 = 0, ir32, ov32;
  logic [2:0]  f32 = '0;
  logic [31:0] a32 = '0, b32 = '0, o32;
  logic        v64 = 0, fl64 = 0, ord64 = 0, ir64, ov64;
  logic [2:0]  f64 = '0;
  logic [63:0] a64 = '0, b64 = '0, o64;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32), .MUL_STAGES(MS32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(v32), .in_ready(ir32), .funct3(f32), .in1(a32),
    .in2(b32), .flush(fl32), .out_valid(ov32), .out_ready(ord32), .out(o32)
  );

  muldiv_unit #(.XLEN(64), .MUL_STAGES(MS64)) dut64 (
    .clk(clk), .rst(rst), .in_valid(v64), .in_ready(ir64), .funct3(f64), .in1(a64),
    .in2(b64), .flush(fl64), .out_valid(ov64), .out_ready(ord64), .out(o64)
  );

  // Issue one op with out_ready high; return edges from accept to out_valid and the result.
  task automatic run32(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res);
    v32 = 1'b1; f32 = f; a32 = a; b32 = b; ord32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0;
    lat = 0;
    while (!ov32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = o32;
    @(posedge clk); #1;
  endtask

  task automatic run64(input logic [2:0] f, input logic [63:0] a, input logic [63:0] b,
                       output int lat, output logic [63:0] res);
    v64 = 1'b1; f64 = f; a64 = a; b64 = b; ord64 = 1'b1;
    @(posedge clk); #1;
    v64 = 1'b0;
    lat = 0;
    while (!ov64 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    res = o64;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    #3;
    n_tests++;
    if ({ir32, ov32, o32} !== {1'b1, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset32: got ready=%b valid=%b out=%h, want 1 0 0", ir32, ov32, o32);
    end
    n_tests++;
    if ({ir64, ov64, o64} !== {1'b1, 1'b0, 64'h0}) begin
      n_fail++;
      $display("FAIL reset64: got ready=%b valid=%b out=%h, want 1 0 0", ir64, ov64, o64);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({ir32, ov32, ir64, ov64} !== 4'b1010) begin
      n_fail++;
      $display("FAIL post_reset: got %b, want 1010", {ir32, ov32, ir64, ov64});
    end
  endtask

  task automatic test_mul;
    logic [2:0]  fs [5] = '{F_MUL, F_MULHU, F_MULH, F_MULHSU, F_MULH};
    logic [31:0] as [5] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
    logic [31:0] bs [5] = '{32'h2, 32'h2, 32'h2, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] es [5] = '{32'hFFFFFFFE, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h0};
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 5; i++) begin
      run32(fs[i], as[i], bs[i], lat, res);
      n_tests++;
      if (res !== es[i]) begin
        n_fail++;
        $display("FAIL mul[%0d] result: got %h, want %h", i, res, es[i]);
      end
      n_tests++;
      if (lat != MS32) begin
        n_fail++;
        $display("FAIL mul[%0d] latency: got %0d, want %0d", i, lat, MS32);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  fs [7] = '{F_DIV, F_REM, F_DIVU, F_REMU, F_DIV, F_REM, F_DIVU};
    logic [31:0] as [7] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100, 32'd7, 32'd7,
                            32'hFFFFFFFF};
    logic [31:0] bs [7] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd1};
    logic [31:0] es [7] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2, 32'hFFFFFFFD, 32'd1,
                            32'hFFFFFFFF};
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 7; i++) begin
      run32(fs[i], as[i], bs[i], lat, res);
      n_tests++;
      if (res !== es[i]) begin
        n_fail++;
        $display("FAIL div[%0d] result: got %h, want %h", i, res, es[i]);
      end
      n_tests++;
      if (lat != 33) begin
        n_fail++;
        $display("FAIL div[%0d] latency: got %0d, want 33", i, lat);
      end
    end
  endtask

  task automatic test_div_corner;
    logic [2:0]  fs [6] = '{F_DIVU, F_REM, F_DIV, F_REM, F_DIV, F_DIVU};
    logic [31:0] as [6] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'hFFFFFFF9,
                            32'h80000000};
    logic [31:0] bs [6] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFFF};
    logic [31:0] es [6] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'hFFFFFFFF, 32'd0};
    int          ls [6] = '{1, 1, 1, 1, 1, 33};
    int lat;
    logic [31:0] res;
    for (int i = 0; i < 6; i++) begin
      run32(fs[i], as[i], bs[i], lat, res);
      n_tests++;
      if (res !== es[i]) begin
        n_fail++;
        $display("FAIL corner[%0d] result: got %h, want %h", i, res, es[i]);
      end
      n_tests++;
      if (lat != ls[i]) begin
        n_fail++;
        $display("FAIL corner[%0d] latency: got %0d, want %0d", i, lat, ls[i]);
      end
    end
  endtask

  task automatic test_back_pressure;
    int lat = 0;
    int seen = 0;
    v32 = 1'b1; f32 = F_MUL; a32 = 32'd3; b32 = 32'd5; ord32 = 1'b0;
    @(posedge clk); #1;
    v32 = 1'b0;
    while (!ov32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat != MS32) begin
      n_fail++;
      $display("FAIL bp latency: got %0d, want %0d", lat, MS32);
    end
    // A request offered while busy must be dropped, not queued.
    v32 = 1'b1; f32 = F_DIVU; a32 = 32'd9; b32 = 32'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if ({ov32, ir32, o32} !== {1'b1, 1'b0, 32'd15}) begin
        n_fail++;
        $display("FAIL bp hold[%0d]: got valid=%b ready=%b out=%h, want 1 0 0000000f",
                 i, ov32, ir32, o32);
      end
    end
    v32 = 1'b0;
    ord32 = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if ({ir32, ov32} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp release: got ready=%b valid=%b, want 1 0", ir32, ov32);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ov32) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL bp ignored_req: got %0d valid cycles, want 0", seen);
    end
  endtask

  task automatic test_flush;
    int seen = 0;
    int lat;
    logic [31:0] res;
    v32 = 1'b1; f32 = F_DIVU; a32 = 32'd1000; b32 = 32'd3; ord32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
    end
    fl32 = 1'b1;
    @(posedge clk); #1;
    fl32 = 1'b0;
    n_tests++;
    if ({ir32, ov32} !== 2'b10) begin
      n_fail++;
      $display("FAIL flush idle: got ready=%b valid=%b, want 1 0", ir32, ov32);
    end
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ov32) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush no_result: got %0d valid cycles, want 0", seen);
    end
    // Flush beats a simultaneous accept.
    v32 = 1'b1; fl32 = 1'b1; f32 = F_MUL; a32 = 32'd6; b32 = 32'd7;
    @(posedge clk); #1;
    v32 = 1'b0; fl32 = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      if (ov32 || !ir32) seen++;
      @(posedge clk); #1;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL flush over_accept: got %0d busy/valid cycles, want 0", seen);
    end
    run32(F_MUL, 32'd3, 32'd4, lat, res);
    n_tests++;
    if (res !== 32'd12 || lat != MS32) begin
      n_fail++;
      $display("FAIL flush then_mul: got %h lat %0d, want 0000000c lat %0d", res, lat, MS32);
    end
  endtask

  task automatic test_reset_mid;
    int seen = 0;
    int lat = 0;
    logic [63:0] res;
    v32 = 1'b1; f32 = F_DIVU; a32 = 32'd1000; b32 = 32'd3; ord32 = 1'b1;
    v64 = 1'b1; f64 = F_DIVU; a64 = 64'd1000; b64 = 64'd3; ord64 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0; v64 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({ir32, ov32, ir64, ov64} !== 4'b1010) begin
      n_fail++;
      $display("FAIL rst_mid async: got %b, want 1010", {ir32, ov32, ir64, ov64});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (ov32 || ov64) seen++;
    end
    n_tests++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rst_mid stale: got %0d valid cycles, want 0", seen);
    end
    // Reset while a result is waiting clears out_valid and out at once.
    v32 = 1'b1; f32 = F_MUL; a32 = 32'd6; b32 = 32'd7; ord32 = 1'b0;
    @(posedge clk); #1;
    v32 = 1'b0;
    while (!ov32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (o32 !== 32'd42) begin
      n_fail++;
      $display("FAIL rst_done pre: got %h, want 0000002a", o32);
    end
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({ov32, o32} !== {1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL rst_done async: got valid=%b out=%h, want 0 0", ov32, o32);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    ord32 = 1'b1;
    run64(F_DIVU, 64'h8000000000000000, 64'd3, lat, res);
    n_tests++;
    if (res !== 64'h2AAAAAAAAAAAAAAA || lat != 65) begin
      n_fail++;
      $display("FAIL divu64: got %h lat %0d, want 2aaaaaaaaaaaaaaa lat 65", res, lat);
    end
    run64(F_MULHU, 64'hFFFFFFFFFFFFFFFF, 64'd2, lat, res);
    n_tests++;
    if (res !== 64'd1 || lat != MS64) begin
      n_fail++;
      $display("FAIL mulhu64: got %h lat %0d, want 1 lat %0d", res, lat, MS64);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_corner();
    test_back_pressure();
    test_flush();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand/result width (legal: 32, 64).
REQ-002 SHALL have parameter MUL_STAGES, default 1, meaning multiplier pipeline register count (legal 1..3).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  unit accepts a request this cycle.
REQ-007 SHALL have port funct3  input  3  RV M-extension op: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-008 SHALL have ports in1, in2  input  XLEN  operands (rs1, rs2).
REQ-009 SHALL have port flush  input  1  abandon any in-flight op.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer takes the result.
REQ-012 SHALL have port out  output  XLEN  result.

Function
REQ-013 SHALL hold one op in flight; FSM states IDLE, MUL, DIV, DONE.
REQ-014 SHALL assert in_ready only in IDLE; accept = in_valid & in_ready; operands and funct3 registered on accept.
REQ-015 SHALL go IDLE->MUL on accepted MUL* op; out_valid rises exactly MUL_STAGES cycles after the accept edge (MUL->DONE).
REQ-016 SHALL compute MUL as the low XLEN bits; MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned x unsigned, high XLEN bits.
REQ-017 SHALL go IDLE->DIV on accepted DIV/DIVU/REM/REMU: restoring divide, 1 quotient bit per cycle, on operand magnitudes; out_valid rises XLEN+1 cycles after the accept edge.
REQ-018 SHALL negate the quotient when signed and operand signs differ; the remainder takes the dividend's sign.
REQ-019 SHALL, for divisor 0, return quotient all-ones and remainder = in1, with out_valid 1 cycle after accept (skip iteration).
REQ-020 SHALL, for signed overflow (in1 = most-negative, in2 = -1), return quotient = in1 and remainder 0, with out_valid 1 cycle after accept.
REQ-021 SHALL hold out and out_valid stable in DONE until out_ready; on out_valid & out_ready go DONE->IDLE, out_valid low next cycle.
REQ-022 SHALL, on flush in any state, go to IDLE next cycle with out_valid low; flush has priority over accept and over the out handshake in the same cycle.
REQ-023 SHALL ignore in_valid outside IDLE (no buffering).

Reset
REQ-024 SHALL, on rst asserted (asynchronously), force state IDLE, out_valid 0, out 0, in_ready 1 while rst is low again and thereafter until accept.
REQ-025 SHALL abort any in-progress MUL or DIV on reset mid-operation; no result is emitted after release.

Structure
REQ-026 SHALL take the funct3 encodings (MUL..REMU) and the FSM state enum from the shared defs package; no local redefinition.
REQ-027 SHALL instantiate one sub-module div_core (XLEN-parameterised, start/busy/done, unsigned iterative divider); sign fix-up and corner cases live in muldiv_unit.
REQ-028 SHALL infer the multiplier as one (XLEN+1)x(XLEN+1) signed product followed by MUL_STAGES-1 pipeline registers.

Verification
REQ-029 SHALL cover MUL 0xFFFFFFFF x 2 (XLEN=32) -> out 0xFFFFFFFE; MULHU same operands -> 0x00000001; MULH -> 0xFFFFFFFF; out_valid at cycle MUL_STAGES.
REQ-030 SHALL cover DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; out_valid exactly XLEN+1 cycles after accept.
REQ-031 SHALL cover DIVU 5 / 0 -> 0xFFFFFFFF and REM 5 / 0 -> 5; DIV 0x80000000 / -1 -> 0x80000000, REM -> 0; each valid 1 cycle after accept.
REQ-032 SHALL cover back-pressure: out_ready low 10 cycles -> out stable, in_ready low; out_ready high -> in_ready high next cycle.
REQ-033 SHALL cover flush at divide cycle 10 -> IDLE next cycle, no out_valid; a following MUL 3 x 4 -> 12.
REQ-034 SHALL cover rst asserted mid-divide between clock edges -> out_valid 0 immediately; no stale result after release; repeat with XLEN=64, DIVU 2^63 / 3 -> 0x2AAAAAAAAAAAAAAA.
